pipeline_hazard_ctrl: RTL and testbench

// Hazard/flow controller for the 5-stage RV32I pipeline. Drives hold and flush (reset2-style)

---
 rtl/pipeline_hazard_ctrl_if.sv | 28 ++
 rtl/pipeline_hazard_ctrl.sv | 61 ++++++
 tb/tb_pipeline_hazard_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: pipeline-stage hazard inputs and the hold/flush/counter controls they produce.
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [4:0] id_rs1, id_rs2;
  logic id_use_rs1, id_use_rs2;
  logic [4:0] ex_rd;
  logic ex_w_reg;
  logic [2:0] ex_r_dm;
  logic mem_branch, mem_isbranch;
  logic [1:0] mem_w_dm;
  logic [2:0] mem_r_dm;
  logic dm_ready;
  logic pc_hold, ifid_hold, idex_hold, exmem_hold;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic pc_sel_branch, mem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_w_reg, ex_r_dm,
           mem_branch, mem_isbranch, mem_w_dm, mem_r_dm, dm_ready,
    input  pc_hold, ifid_hold, idex_hold, exmem_hold, ifid_flush, idex_flush,
           exmem_flush, memwb_flush, pc_sel_branch, mem_timeout, stall_cnt, flush_cnt
  );
  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_w_reg, ex_r_dm,
           mem_branch, mem_isbranch, mem_w_dm, mem_r_dm, dm_ready,
    output pc_hold, ifid_hold, idex_hold, exmem_hold, ifid_flush, idex_flush,
           exmem_flush, memwb_flush, pc_sel_branch, mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use stall, taken-branch flush and data-memory wait/timeout control for a 5-stage pipeline.
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input logic clk,
  input logic reset,
  pipeline_hazard_ctrl_if.slave h
);
  localparam int WW = $clog2(TIMEOUT) + 1;
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;
  state_t state, state_nx;
  logic [WW-1:0] wait_cnt, wait_nx;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic mem_acc, taken, lu, freeze, br, ld;
  always_comb begin
    mem_acc  = (h.mem_w_dm != '0) | (h.mem_r_dm != '0);
    taken    = h.mem_branch & h.mem_isbranch;
    lu       = (h.ex_r_dm != '0) & h.ex_w_reg & (h.ex_rd != '0) &
               ((h.id_use_rs1 & (h.id_rs1 == h.ex_rd)) | (h.id_use_rs2 & (h.id_rs2 == h.ex_rd)));
    // controls are forced low while reset is asserted, regardless of inputs
    freeze   = reset & (((state == RUN) & mem_acc & !h.dm_ready) |
                        ((state == MEM_WAIT) & !h.dm_ready) | (state == ERR));
    br       = reset & !freeze & taken;
    ld       = reset & !freeze & !taken & lu;
    state_nx = state;
    wait_nx  = wait_cnt;
    if (state == RUN && mem_acc && !h.dm_ready) begin
      state_nx = MEM_WAIT;
      wait_nx  = WW'(1);
    end else if (state == MEM_WAIT) begin
      state_nx = h.dm_ready ? RUN : (wait_cnt == WW'(TIMEOUT - 1)) ? ERR : MEM_WAIT;
      wait_nx  = h.dm_ready ? '0 : wait_cnt + WW'(1);
    end
  end
  assign h.pc_hold       = freeze | ld;
  assign h.ifid_hold     = freeze | ld;
  assign h.idex_hold     = freeze;
  assign h.exmem_hold    = freeze;
  assign h.ifid_flush    = br;
  assign h.idex_flush    = br | ld;
  assign h.exmem_flush   = br;
  assign h.memwb_flush   = freeze;
  assign h.pc_sel_branch = br;
  assign h.mem_timeout   = state == ERR;
  assign h.stall_cnt     = stall_cnt;
  assign h.flush_cnt     = flush_cnt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_nx;
      wait_cnt  <= wait_nx;
      if (h.pc_hold && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (br && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed vectors, cycle-by-cycle check against a rule-level model plus literal expectations.
module tb_pipeline_hazard_ctrl;
  localparam int TO = 4;
  localparam int CW = 4;
  localparam int MAXC = (1 << CW) - 1;
  logic clk = 0;
  logic reset = 1;
  int vectors = 0;
  int miscompares = 0;
  pipeline_hazard_ctrl_if #(.CNT_W(CW)) h();
  pipeline_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .h(h));
  always #5 clk = ~clk;
  bit m_err = 0, m_wait = 0;
  int m_n = 0, m_stall = 0, m_flush = 0;
  logic e_frz, e_tk, e_lu, e_ph, acc, dep;
  always_comb begin
    acc   = (h.mem_w_dm != 0) || (h.mem_r_dm != 0);
    dep   = (h.ex_r_dm != 0) && h.ex_w_reg && (h.ex_rd != 0) &&
            ((h.id_use_rs1 && h.id_rs1 == h.ex_rd) || (h.id_use_rs2 && h.id_rs2 == h.ex_rd));
    e_frz = reset && (m_err || (!h.dm_ready && (m_wait || acc)));
    e_tk  = reset && !e_frz && h.mem_branch && h.mem_isbranch;
    e_lu  = reset && !e_frz && !(h.mem_branch && h.mem_isbranch) && dep;
    e_ph  = e_frz || e_lu;
  end
  // error after TO consecutive frozen cycles; counters saturate
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_err <= 0; m_wait <= 0; m_n <= 0; m_stall <= 0; m_flush <= 0;
    end else begin
      if (e_frz && !m_err) begin
        m_wait <= 1;
        m_n <= m_n + 1;
        if (m_n + 1 >= TO) m_err <= 1;
      end else if (!e_frz) begin
        m_wait <= 0;
        m_n <= 0;
      end
      if (e_ph && m_stall < MAXC) m_stall <= m_stall + 1;
      if (e_tk && m_flush < MAXC) m_flush <= m_flush + 1;
    end
  end
  task automatic check(input string n, input int a, input int e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask
  always @(negedge clk) begin
    check("pc_hold", int'(h.pc_hold), int'(e_ph));
    check("ifid_hold", int'(h.ifid_hold), int'(e_ph));
    check("idex_hold", int'(h.idex_hold), int'(e_frz));
    check("exmem_hold", int'(h.exmem_hold), int'(e_frz));
    check("ifid_flush", int'(h.ifid_flush), int'(e_tk));
    check("idex_flush", int'(h.idex_flush), int'(e_tk || e_lu));
    check("exmem_flush", int'(h.exmem_flush), int'(e_tk));
    check("memwb_flush", int'(h.memwb_flush), int'(e_frz));
    check("pc_sel_branch", int'(h.pc_sel_branch), int'(e_tk));
    check("mem_timeout", int'(h.mem_timeout), int'(m_err));
    check("stall_cnt", int'(h.stall_cnt), m_stall);
    check("flush_cnt", int'(h.flush_cnt), m_flush);
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    h.id_rs1 = 0; h.id_rs2 = 0; h.id_use_rs1 = 0; h.id_use_rs2 = 0;
    h.ex_rd = 0; h.ex_w_reg = 0; h.ex_r_dm = 0;
    h.mem_branch = 0; h.mem_isbranch = 0; h.mem_w_dm = 0; h.mem_r_dm = 0;
    h.dm_ready = 1;
  endtask
  task automatic set_lu(input logic [4:0] r);
    h.ex_rd = r; h.ex_w_reg = 1; h.ex_r_dm = 3'b010; h.id_rs2 = r; h.id_use_rs2 = 1;
  endtask
  logic [4:0] t_rs1 [6] = '{9, 9, 9, 9, 3, 3};
  logic [4:0] t_rs2 [6] = '{0, 9, 9, 9, 4, 4};
  logic [4:0] t_rd  [6] = '{9, 9, 9, 9, 3, 4};
  logic       t_u1  [6] = '{1, 0, 1, 1, 0, 0};
  logic       t_u2  [6] = '{0, 0, 1, 1, 1, 1};
  logic       t_w   [6] = '{1, 1, 0, 1, 1, 1};
  logic [2:0] t_r   [6] = '{1, 1, 1, 0, 7, 7};
  int         t_exp [6] = '{1, 0, 0, 0, 0, 1};
  initial begin
    idle();
    #1 reset = 0;
    set_lu(5);
    @(negedge clk);
    check("lit_rst_pc_hold", int'(h.pc_hold), 0);
    check("lit_rst_idex_flush", int'(h.idex_flush), 0);
    check("lit_rst_stall", int'(h.stall_cnt), 0);
    cyc(); reset = 1;
    @(negedge clk);
    check("lit_lu_pc_hold", int'(h.pc_hold), 1);
    check("lit_lu_ifid_hold", int'(h.ifid_hold), 1);
    check("lit_lu_idex_flush", int'(h.idex_flush), 1);
    check("lit_lu_idex_hold", int'(h.idex_hold), 0);
    cyc(); idle();
    @(negedge clk);
    check("lit_lu_stall_cnt", int'(h.stall_cnt), 1);
    cyc(); h.ex_rd = 0; h.ex_w_reg = 1; h.ex_r_dm = 1; h.id_rs1 = 0; h.id_use_rs1 = 1;
    @(negedge clk);
    check("lit_x0_pc_hold", int'(h.pc_hold), 0);
    check("lit_x0_idex_flush", int'(h.idex_flush), 0);
    cyc(); idle(); set_lu(7); h.mem_branch = 1; h.mem_isbranch = 1;
    @(negedge clk);
    check("lit_br_pc_sel", int'(h.pc_sel_branch), 1);
    check("lit_br_ifid_flush", int'(h.ifid_flush), 1);
    check("lit_br_exmem_flush", int'(h.exmem_flush), 1);
    check("lit_br_pc_hold", int'(h.pc_hold), 0);
    cyc(); h.mem_isbranch = 0;
    @(negedge clk);
    check("lit_nt_pc_hold", int'(h.pc_hold), 1);
    cyc(); idle();
    @(negedge clk);
    check("lit_br_flush_cnt", int'(h.flush_cnt), 1);
    check("lit_br_stall_cnt", int'(h.stall_cnt), 2);
    cyc(); reset = 0;
    #1 check("lit_rst2_stall", int'(h.stall_cnt), 0);
    check("lit_rst2_flush", int'(h.flush_cnt), 0);
    cyc(); reset = 1; h.mem_w_dm = 2'b01; h.dm_ready = 0;
    @(negedge clk);
    check("lit_st_pc_hold", int'(h.pc_hold), 1);
    check("lit_st_memwb_flush", int'(h.memwb_flush), 1);
    check("lit_st_exmem_hold", int'(h.exmem_hold), 1);
    set_lu(6); h.mem_branch = 1; h.mem_isbranch = 1;
    repeat (2) begin
      cyc();
      @(negedge clk);
      check("lit_st_frz_hold", int'(h.pc_hold), 1);
      check("lit_st_frz_pc_sel", int'(h.pc_sel_branch), 0);
      check("lit_st_frz_idex_flush", int'(h.idex_flush), 0);
    end
    cyc(); idle();
    @(negedge clk);
    check("lit_st_rdy_pc_hold", int'(h.pc_hold), 0);
    check("lit_st_rdy_memwb", int'(h.memwb_flush), 0);
    cyc(); h.dm_ready = 0;
    @(negedge clk);
    check("lit_st_stall_cnt", int'(h.stall_cnt), 3);
    check("lit_noacc_pc_hold", int'(h.pc_hold), 0);
    cyc(); h.mem_r_dm = 3'b100;
    @(negedge clk);
    check("lit_to_first", int'(h.mem_timeout), 0);
    repeat (3) begin
      cyc();
      @(negedge clk);
      check("lit_to_hold", int'(h.pc_hold), 1);
      check("lit_to_wait", int'(h.mem_timeout), 0);
    end
    cyc(); h.dm_ready = 1;
    @(negedge clk);
    check("lit_to_err", int'(h.mem_timeout), 1);
    check("lit_to_err_hold", int'(h.pc_hold), 1);
    repeat (14) cyc();
    @(negedge clk);
    check("lit_stall_sat", int'(h.stall_cnt), 15);
    check("lit_to_sticky", int'(h.mem_timeout), 1);
    cyc(); #2 reset = 0;
    #1 check("lit_arst_timeout", int'(h.mem_timeout), 0);
    check("lit_arst_pc_hold", int'(h.pc_hold), 0);
    check("lit_arst_stall", int'(h.stall_cnt), 0);
    cyc(); reset = 1; idle();
    @(negedge clk);
    check("lit_post_err_hold", int'(h.pc_hold), 0);
    for (int i = 0; i < 6; i++) begin
      cyc(); idle();
      h.id_rs1 = t_rs1[i]; h.id_rs2 = t_rs2[i]; h.ex_rd = t_rd[i];
      h.id_use_rs1 = t_u1[i]; h.id_use_rs2 = t_u2[i]; h.ex_w_reg = t_w[i]; h.ex_r_dm = t_r[i];
      @(negedge clk);
      check($sformatf("lit_tab%0d_pc_hold", i), int'(h.pc_hold), t_exp[i]);
    end
    cyc(); idle(); h.mem_branch = 1; h.mem_isbranch = 1;
    repeat (20) cyc();
    idle();
    @(negedge clk);
    check("lit_flush_sat", int'(h.flush_cnt), 15);
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1);
  end
endmodule
